// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: two-master AXI read-channel arbiter.
// Master 0 is the i-cache refill port, master 1 the d-cache refill port.
// One burst is outstanding at a time. Winners are picked round-robin in
// IDLE, the address is replayed to memory from a registered copy, and
// returning beats are steered combinationally to the granted master until
// max(ARLEN,1) beats have been accepted. ARLEN is a beat count, not len-1.

module mem_read_arbiter #(
    parameter int MAX_BEATS = 16,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    localparam int LEN_W    = $clog2(MAX_BEATS) + 1
) (
    input  logic              clk,
    input  logic              rst_n,

    // master 0 (i-cache) read address
    input  logic              m0_arvalid,
    output logic              m0_arready,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [LEN_W-1:0]  m0_arlen,
    input  logic [ID_W-1:0]   m0_arid,
    // master 0 (i-cache) read data
    output logic              m0_rvalid,
    input  logic              m0_rready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [ID_W-1:0]   m0_rid,
    output logic              m0_rlast,

    // master 1 (d-cache) read address
    input  logic              m1_arvalid,
    output logic              m1_arready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [LEN_W-1:0]  m1_arlen,
    input  logic [ID_W-1:0]   m1_arid,
    // master 1 (d-cache) read data
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ID_W-1:0]   m1_rid,
    output logic              m1_rlast,

    // memory read address
    output logic              mem_arvalid,
    input  logic              mem_arready,
    output logic [ADDR_W-1:0] mem_araddr,
    output logic [LEN_W-1:0]  mem_arlen,
    output logic [ID_W-1:0]   mem_arid,
    // memory read data
    input  logic              mem_rvalid,
    output logic              mem_rready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [ID_W-1:0]   mem_rid,
    input  logic              mem_rlast
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    state_t              ctrl_state_s;

    logic                grant_r;
    logic                last_grant_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [LEN_W-1:0]    len_r;
    logic [ID_W-1:0]     id_r;
    logic [LEN_W-1:0]    cnt_r;

    logic                any_req_s;
    logic                winner_s;
    logic                beat_s;
    logic                last_beat_s;
    logic [LEN_W-1:0]    eff_len_s;
    logic [LEN_W-1:0]    cnt_plus_s;

    // Round-robin pick: a lone requester wins, a tie goes to the master that did not win last time.
    always_comb begin
        any_req_s = m0_arvalid | m1_arvalid;
        if (m0_arvalid && m1_arvalid) begin
            winner_s = ~last_grant_r;
        end else if (m1_arvalid) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // While reset is held the outputs behave as IDLE so stale memory beats are sunk, not delivered.
    always_comb begin
        if (rst_n) begin
            ctrl_state_s = state_r;
        end else begin
            ctrl_state_s = IDLE;
        end
    end

    // Beat accounting: ARLEN of zero is treated as a single-beat burst.
    always_comb begin
        if (len_r == {LEN_W{1'b0}}) begin
            eff_len_s = LEN_W'(1);
        end else begin
            eff_len_s = len_r;
        end
        cnt_plus_s  = cnt_r + LEN_W'(1);
        beat_s      = mem_rvalid & mem_rready;
        last_beat_s = (cnt_plus_s == eff_len_s);
    end

    // Handshake and data steering; data/ID buses fan out to both masters, only valid/last are qualified.
    always_comb begin
        m0_arready  = 1'b0;
        m1_arready  = 1'b0;
        m0_rvalid   = 1'b0;
        m1_rvalid   = 1'b0;
        m0_rlast    = 1'b0;
        m1_rlast    = 1'b0;
        m0_rdata    = mem_rdata;
        m1_rdata    = mem_rdata;
        m0_rid      = mem_rid;
        m1_rid      = mem_rid;
        mem_arvalid = 1'b0;
        mem_araddr  = addr_r;
        mem_arlen   = len_r;
        mem_arid    = id_r;
        mem_rready  = 1'b1;
        case (ctrl_state_s)
            IDLE: begin
                m0_arready = any_req_s & ~winner_s;
                m1_arready = any_req_s &  winner_s;
            end
            ADDR: begin
                mem_arvalid = 1'b1;
            end
            DATA: begin
                if (grant_r) begin
                    m1_rvalid  = mem_rvalid;
                    m1_rlast   = mem_rlast;
                    mem_rready = m1_rready;
                end else begin
                    m0_rvalid  = mem_rvalid;
                    m0_rlast   = mem_rlast;
                    mem_rready = m0_rready;
                end
            end
            default: begin
                mem_rready = 1'b1;
            end
        endcase
    end

    // Next-state logic; memory RLAST is deliberately ignored, the beat count ends the burst.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ADDR;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ADDR: begin
                if (mem_arready) begin
                    state_nxt_s = DATA;
                end else begin
                    state_nxt_s = ADDR;
                end
            end
            DATA: begin
                if (beat_s && last_beat_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DATA;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register and grant bookkeeping; last_grant resets to m1 so m0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == IDLE) && any_req_s) begin
                grant_r      <= winner_s;
                last_grant_r <= winner_s;
            end else begin
                grant_r      <= grant_r;
                last_grant_r <= last_grant_r;
            end
        end
    end

    // Address fields are sampled only in the IDLE acceptance cycle; later master changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_r <= {ADDR_W{1'b0}};
            len_r  <= {LEN_W{1'b0}};
            id_r   <= {ID_W{1'b0}};
        end else if ((state_r == IDLE) && any_req_s) begin
            if (winner_s) begin
                addr_r <= m1_araddr;
                len_r  <= m1_arlen;
                id_r   <= m1_arid;
            end else begin
                addr_r <= m0_araddr;
                len_r  <= m0_arlen;
                id_r   <= m0_arid;
            end
        end else begin
            addr_r <= addr_r;
            len_r  <= len_r;
            id_r   <= id_r;
        end
    end

    // Beat counter: cleared when memory takes the address, advanced on each accepted data beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {LEN_W{1'b0}};
        end else if ((state_r == ADDR) && mem_arready) begin
            cnt_r <= {LEN_W{1'b0}};
        end else if ((state_r == DATA) && beat_s) begin
            cnt_r <= cnt_plus_s;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    mem_read_arbiter_props #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W),
        .ID_W   (ID_W)
    ) u_props (
        .clk         (clk),
        .rst_n       (rst_n),
        .m0_arready  (m0_arready),
        .m1_arready  (m1_arready),
        .m0_rvalid   (m0_rvalid),
        .m1_rvalid   (m1_rvalid),
        .mem_arvalid (mem_arvalid),
        .mem_arready (mem_arready),
        .mem_araddr  (mem_araddr),
        .mem_arlen   (mem_arlen),
        .mem_arid    (mem_arid)
    );

endmodule

// Protocol properties of the arbiter outputs.
module mem_read_arbiter_props #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 5,
    parameter int ID_W   = 4
) (
    input logic              clk,
    input logic              rst_n,
    input logic              m0_arready,
    input logic              m1_arready,
    input logic              m0_rvalid,
    input logic              m1_rvalid,
    input logic              mem_arvalid,
    input logic              mem_arready,
    input logic [ADDR_W-1:0] mem_araddr,
    input logic [LEN_W-1:0]  mem_arlen,
    input logic [ID_W-1:0]   mem_arid
);

    a_one_arready: assert property (@(posedge clk) !(m0_arready && m1_arready));

    a_one_rvalid: assert property (@(posedge clk) !(m0_rvalid && m1_rvalid));

    a_ar_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (mem_arvalid && !mem_arready) |=>
            (mem_arvalid && $stable(mem_araddr) && $stable(mem_arlen) && $stable(mem_arid)));

endmodule
